frame_sched: RTL
================

FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 8000: idle-low latch gap after a frame, in clk_in cycles (100 us at 80 MHz); range 2 to 2^20-1.
REQ-002 Parameter REFRESH_CYCLES, default 8000000: auto-refresh period in clk_in cycles (100 ms at 80 MHz); range 16 to 2^24-1.
REQ-003 Parameter GUARD_CYCLES, default 2: cycles after start during which layer_busy_in is ignored; range 1 to 15.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: clk_in (system clock) and rst_n_in (asynchronous, active low).
REQ-005 clk_in  input  1  system clock; all logic is on the rising edge.
REQ-006 rst_n_in  input  1  asynchronous active-low reset.
REQ-007 frame_rdy_in  input  1  one-cycle pulse from the frame assembler: a new frame is buffered.
REQ-008 layer_busy_in  input  8  per-layer serializer busy flags.
REQ-009 frame_start_out  output  1  one-cycle pulse that starts all layer serializers.
REQ-010 sched_busy_out  output  1  high whenever the state is not IDLE.
REQ-011 drop_cnt_out  output  8  saturating count of host frames overwritten before they were sent.

Function
REQ-012 The block SHALL implement the states IDLE, START, GUARD, RUN and GAP.
REQ-013 IDLE: if pend=1, go to START in the next cycle.
REQ-014 START: frame_start_out=1 for exactly this cycle; clear pend; go to GUARD.
REQ-015 GUARD: stay GUARD_CYCLES cycles, ignoring layer_busy_in; then go to RUN.
REQ-016 RUN: remain while any layer_busy_in bit is 1; when all bits are 0, go to GAP.
REQ-017 GAP: count GAP_CYCLES cycles, then go to IDLE; frame_start_out is never asserted in GAP.
REQ-018 Pending request: frame_rdy_in=1 sets pend in the next cycle, in any state.
REQ-019 If frame_rdy_in=1 while pend=1 and the state is not START, drop_cnt_out SHALL increment by 1, saturating at 255.
REQ-020 frame_rdy_in=1 in the START cycle SHALL set pend (the clear does not win) and SHALL NOT count a drop.
REQ-021 Latency: frame_rdy_in in IDLE with pend=0 gives frame_start_out exactly 2 cycles later.
REQ-022 Minimum spacing between start pulses: 1 + GUARD_CYCLES + 1 + GAP_CYCLES cycles.
REQ-023 If layer_busy_in is already 0 when GUARD ends, RUN SHALL last exactly 1 cycle.
REQ-024 The gap counter and the refresh counter SHALL each be sized by $clog2 of their parameter, with no wrap before terminal count.

Reset
REQ-025 On rst_n_in=0: state=IDLE, pend=0, counters=0, frame_start_out=0, sched_busy_out=0, drop_cnt_out=0.
REQ-026 Reset in any state SHALL abort immediately, with no start pulse.
REQ-027 Reset release SHALL be taken synchronously to clk_in.

Configuration
REQ-028 Macro FRAME_SCHED_AUTO_REFRESH_EN, when defined, adds the auto-refresh feature:
- A refresh counter increments in IDLE and clears on each frame_start_out.
- At REFRESH_CYCLES it sets pend and is not counted as a drop.
REQ-029 When FRAME_SCHED_AUTO_REFRESH_EN is undefined, no refresh counter exists and starts occur only from frame_rdy_in.

Structure
REQ-030 Shared package ws2812_pkg SHALL hold the state enum type frame_sched_state_t, LAYER_NUM=8, and the default cycle constants.
REQ-031 One sub-module, cycle_timer (load, terminal-count pulse, parameterized width), SHALL be instantiated for the gap timer and the refresh timer.

Verification (GAP_CYCLES=10, REFRESH_CYCLES=50, GUARD_CYCLES=2)
REQ-032 Single frame: frame_rdy_in pulse at cycle 0, busy high for cycles 3-20 -> start at cycle 2, IDLE at cycle 32, drop_cnt_out=0.
REQ-033 Overrun: three frame_rdy_in pulses during RUN -> exactly one further start after GAP, drop_cnt_out=2.
REQ-034 Coincidence: frame_rdy_in in the START cycle -> second start exactly 14 cycles after the first (busy held 0), drop_cnt_out=0.
REQ-035 Saturation: 300 overrun pulses -> drop_cnt_out=255 and it holds.
REQ-036 Reset mid-RUN: assert rst_n_in -> all outputs 0 immediately; after release, no start without a new request.
REQ-037 Auto-refresh, macro defined: no frame_rdy_in for 50 IDLE cycles -> start pulse, and drop_cnt_out unchanged.
REQ-038 Auto-refresh, macro undefined: same stimulus -> no start pulse.

Source files
------------

// File: rtl/ws2812_pkg.sv
// -----------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 frame scheduling logic: layer count,
// default timing constants (80 MHz clock), the scheduler state type and a
// small saturating-increment helper.
// -----------------------------------------------------------------------------
`default_nettype none

package ws2812_pkg;

  localparam int LAYER_NUM          = 8;
  localparam int DEF_GAP_CYCLES     = 8000;     // 100 us at 80 MHz
  localparam int DEF_REFRESH_CYCLES = 8000000;  // 100 ms at 80 MHz
  localparam int DEF_GUARD_CYCLES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_GUARD = 3'd2,
    ST_RUN   = 3'd3,
    ST_GAP   = 3'd4
  } frame_sched_state_t;

  // Increment an 8-bit counter, holding at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_sched_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Up-counter that pulses tc on the LIMIT-th enabled cycle after a load and
// then restarts from zero. Width is $clog2(LIMIT): the count only ever spans
// 0 .. LIMIT-1, so it never wraps before the terminal count.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   load   - clear the count to zero (wins over en)
//   en     - count this cycle
//   tc     - terminal-count pulse (combinational, qualified by en)
// -----------------------------------------------------------------------------
`default_nettype none

module cycle_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int              WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  assign tc = en && !load && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_sched.sv
// -----------------------------------------------------------------------------
// frame_sched
// Schedules WS2812 frame transmissions: a frame request (or optional periodic
// refresh) raises a pending flag, the FSM issues a one-cycle start pulse to
// all layer serializers, waits out a guard window, waits for every layer to
// go idle, then enforces the latch gap before the next start. Requests that
// arrive while one is already pending are counted as dropped frames.
//
// Ports:
//   clk_in          - system clock, rising edge
//   rst_n_in        - asynchronous active-low reset
//   frame_rdy_in    - one-cycle pulse: new frame buffered
//   layer_busy_in   - per-layer serializer busy flags
//   frame_start_out - one-cycle start pulse to the serializers
//   sched_busy_out  - high whenever the scheduler is not idle
//   drop_cnt_out    - saturating count of overwritten requests
//
// Build option: FRAME_SCHED_AUTO_REFRESH_EN adds a refresh timer that raises
// a pending request after REFRESH_CYCLES idle cycles.
// -----------------------------------------------------------------------------
`default_nettype none

module frame_sched
  import ws2812_pkg::*;
#(
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 frame_rdy_in,
  input  logic [LAYER_NUM-1:0] layer_busy_in,
  output logic                 frame_start_out,
  output logic                 sched_busy_out,
  output logic [7:0]           drop_cnt_out
);

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

  frame_sched_state_t state;
  logic [3:0]         guard_cnt;
  logic               pend;
  logic               gap_done;
  logic               refresh_due;

  cycle_timer #(
    .LIMIT (GAP_CYCLES)
  ) u_gap_timer (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .load  (state != ST_GAP),
    .en    (state == ST_GAP),
    .tc    (gap_done)
  );

`ifdef FRAME_SCHED_AUTO_REFRESH_EN
  // Counts idle cycles only; the start pulse restarts the period.
  cycle_timer #(
    .LIMIT (REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .load  (frame_start_out),
    .en    (state == ST_IDLE),
    .tc    (refresh_due)
  );
`else
  assign refresh_due = 1'b0;
`endif

  // A new request always wins over the clear in START, so a request landing
  // exactly on the start pulse is kept for the next frame and is not a drop.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend         <= 1'b0;
      drop_cnt_out <= 8'd0;
    end else begin
      pend <= frame_rdy_in | refresh_due | (pend & (state != ST_START));
      if (frame_rdy_in && pend && (state != ST_START)) begin
        drop_cnt_out <= sat_inc8(drop_cnt_out);
      end
    end
  end

  // Outputs are registered alongside the state so frame_start_out is high
  // exactly in the START cycle and sched_busy_out exactly when not IDLE.
  // At the end of GAP a pending request goes straight to START, which makes
  // back-to-back frames 1 + GUARD + 1 + GAP cycles apart.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= ST_IDLE;
      guard_cnt       <= 4'd0;
      frame_start_out <= 1'b0;
      sched_busy_out  <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pend) begin
            state           <= ST_START;
            frame_start_out <= 1'b1;
            sched_busy_out  <= 1'b1;
          end
        end
        ST_START: begin
          state     <= ST_GUARD;
          guard_cnt <= 4'd0;
        end
        ST_GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state <= ST_RUN;
          end else begin
            guard_cnt <= guard_cnt + 4'd1;
          end
        end
        ST_RUN: begin
          if (~|layer_busy_in) begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            if (pend) begin
              state           <= ST_START;
              frame_start_out <= 1'b1;
            end else begin
              state          <= ST_IDLE;
              sched_busy_out <= 1'b0;
            end
          end
        end
        default: begin
          state          <= ST_IDLE;
          sched_busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
